// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and sticky error flags.
// Defining MCTRL_JAL_EN adds the JAL state; otherwise opcode 3 is illegal.
module multicycle_ctrl #(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         pc_source,
    output logic [2:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               bus_err,
    output logic [3:0]         state_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWr   = 4'd6,
        StWbMem   = 4'd7,
        StWbAlu   = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
`ifdef MCTRL_JAL_EN
        StJal     = 4'd11,
`endif
        StError   = 4'd12
    } state_e;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluXor   = 3'b100;
    localparam logic [2:0] AluSlt   = 3'b101;
    localparam logic [2:0] AluFunct = 3'b110;

    // Counter value on the last wait cycle allowed before a bus error.
    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic [2:0] alu_code;
    logic       wait_expired;

    assign wait_expired = (wait_q == TimeoutLast);

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        pc_source     = 2'b00;
        alu_src_b     = 3'b000;
        alu_code      = AluAdd;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 3'b001;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (wait_expired) begin
                    state_d   = StError;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                alu_src_b = 3'b101;
                case (opcode)
                    6'd0:                       state_d = StExecR;
                    6'd4, 6'd5:                 state_d = StBranch;
                    6'd8, 6'd10, 6'd11, 6'd12,
                    6'd13, 6'd14, 6'd15:        state_d = StExecI;
                    6'd35, 6'd43:               state_d = StMemAddr;
                    6'd2:                       state_d = StJump;
`ifdef MCTRL_JAL_EN
                    6'd3:                       state_d = StJal;
`endif
                    default: begin
                        state_d   = StError;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_code  = AluFunct;
                state_d   = StWbAlu;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                state_d   = StWbAlu;
                case (opcode)
                    6'd10, 6'd11: begin alu_code = AluSlt; alu_src_b = 3'b010; end
                    6'd12:        begin alu_code = AluAnd; alu_src_b = 3'b011; end
                    6'd13:        begin alu_code = AluOr;  alu_src_b = 3'b011; end
                    6'd14:        begin alu_code = AluXor; alu_src_b = 3'b011; end
                    6'd15:        begin alu_code = AluAdd; alu_src_b = 3'b100; end
                    default:      begin alu_code = AluAdd; alu_src_b = 3'b010; end
                endcase
            end
            StWbAlu: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == 6'd0) ? 2'b01 : 2'b00;
                state_d   = StFetch;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'b010;
                state_d   = (opcode == 6'd35) ? StMemRd : StMemWr;
            end
            StMemRd, StMemWr: begin
                i_or_d    = 1'b1;
                mem_read  = (state_q == StMemRd);
                mem_write = (state_q == StMemWr);
                if (mem_ready) begin
                    state_d = (state_q == StMemRd) ? StWbMem : StFetch;
                end else if (wait_expired) begin
                    state_d   = StError;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_code      = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (opcode == 6'd5);
                state_d       = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = StFetch;
            end
`ifdef MCTRL_JAL_EN
            StJal: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                state_d    = StFetch;
            end
`endif
            default: state_d = StError;
        endcase

        // Hold every strobe and select low while reset is asserted.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            ir_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            reg_dst       = 2'b00;
            mem_to_reg    = 2'b00;
            pc_source     = 2'b00;
            alu_src_b     = 3'b000;
            alu_code      = AluAdd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign alu_op  = ALUOP_W'(alu_code);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL provide parameter ALUOP_W, default 3, meaning alu_op width (legal values ≥3; codes zero-extended to this width).
REQ-002 The block SHALL provide parameter MEM_TIMEOUT, default 15, meaning the maximum number of wait cycles on mem_ready before a bus error (legal range 1..255).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 pc_write, pc_write_cond, branch_ne, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a  output  1 each  datapath strobes and selects.
REQ-009 reg_dst, mem_to_reg, pc_source  output  2 each  selects: reg_dst 00=rt, 01=rd, 10=$31; mem_to_reg 00=ALU, 01=MDR, 10=PC; pc_source 00=ALU, 01=ALUOut, 10=jump target.
REQ-010 alu_src_b  output  3  select: 000=B, 001=4, 010=sign-ext imm, 011=zero-ext imm, 100=imm<<16, 101=sign-ext imm<<2.
REQ-011 alu_op  output  ALUOP_W  codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 funct-decoded.
REQ-012 illegal, bus_err  output  1 each  sticky error flags.
REQ-013 state_o  output  4  current state encoding, for debug.

Function
REQ-014 The block SHALL implement the states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JUMP, JAL, and ERROR.
REQ-015 Any output not driven by the current state SHALL be 0.
REQ-016 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=001, alu_op=add, pc_source=00; ir_write and pc_write SHALL be 1 only in a cycle where mem_ready=1 (these are Mealy outputs); on mem_ready=1 the next state SHALL be DECODE, otherwise FETCH.
REQ-017 DECODE SHALL last one cycle with alu_src_a=0, alu_src_b=101, alu_op=add, and SHALL branch on opcode: 0→EXEC_R; 4,5→BRANCH; 8,10,11,12,13,14,15→EXEC_I; 35,43→MEM_ADDR; 2→JUMP; 3→JAL (macro-dependent); any other opcode→ERROR with illegal=1.
REQ-018 EXEC_R SHALL drive alu_src_a=1, alu_src_b=000, alu_op=110; the next state SHALL be WB_ALU with reg_dst=01.
REQ-019 EXEC_I SHALL drive alu_src_a=1 with per-opcode alu_op and alu_src_b: addi add/010; slti and sltiu slt/010; andi and/011; ori or/011; xori xor/011; lui add/100. The next state SHALL be WB_ALU with reg_dst=00.
REQ-020 WB_ALU SHALL drive reg_write=1, mem_to_reg=00 and return to FETCH.
REQ-021 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=010, alu_op=add; the next state SHALL be MEM_RD (opcode 35) or MEM_WR (opcode 43).
REQ-022 MEM_RD and MEM_WR SHALL drive i_or_d=1 with mem_read=1 or mem_write=1 respectively and SHALL hold until mem_ready=1; MEM_RD then goes to WB_MEM (reg_write=1, mem_to_reg=01, reg_dst=00), and MEM_WR goes to FETCH.
REQ-023 BRANCH SHALL drive alu_src_a=1, alu_src_b=000, alu_op=sub, pc_write_cond=1, pc_source=01, branch_ne=1 for opcode 5 only, then return to FETCH.
REQ-024 JUMP SHALL drive pc_write=1, pc_source=10, then return to FETCH.
REQ-025 Unstalled latencies SHALL be: branch and j 3 cycles, R-type, I-type and sw 4 cycles, lw 5 cycles.
REQ-026 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and SHALL increment on each cycle in which mem_ready=0 in those states; when it reaches MEM_TIMEOUT with mem_ready still 0, the next state SHALL be ERROR with bus_err=1.
REQ-027 If mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, the access SHALL complete normally.
REQ-028 ERROR SHALL be absorbing, SHALL assert no strobes, and SHALL keep illegal and bus_err held until reset.

Reset
REQ-029 When rst_n=0 at a rising clk edge, the state SHALL become FETCH, the wait counter, illegal and bus_err SHALL clear, and all Moore outputs SHALL be 0 in the cycle following reset, regardless of any operation in progress.
REQ-030 ir_write and pc_write SHALL be forced to 0 while rst_n=0.

Configuration
REQ-031 With macro MCTRL_JAL_EN defined, opcode 3 SHALL go to JAL, which drives pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, then returns to FETCH (3 cycles).
REQ-032 Without MCTRL_JAL_EN, the JAL state SHALL be absent and opcode 3 SHALL go to ERROR with illegal=1.

Verification
REQ-033 add (opcode 0), mem_ready tied to 1 → states FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1 only in cycle 4 with reg_dst=01.
REQ-034 lw (opcode 35), mem_ready low for 3 cycles in MEM_RD → lw completes in 8 cycles; mem_read held for 4 cycles; WB_MEM has mem_to_reg=01.
REQ-035 bne (opcode 5) → 3 cycles; in BRANCH, pc_write_cond=1, branch_ne=1, alu_op=001.
REQ-036 MEM_TIMEOUT=4, mem_ready held 0 during FETCH → after 4 wait cycles the state is ERROR and bus_err=1; bus_err stays set until rst_n=0, then the state returns to FETCH.
REQ-037 Opcode 6'd63 → ERROR with illegal=1; opcode 3 → JAL with MCTRL_JAL_EN defined, ERROR with illegal=1 without it.
REQ-038 rst_n=0 asserted during MEM_WR → the next state is FETCH, and mem_write=0 in the cycle following reset.
